// File: rtl/ex_wb_stage.sv
// ex_wb_stage -- execute and write-back stage of the 8-bit pipelined core.
//
// Selects the EX result (immediate, or the source operand with optional
// immediate add), forwards the previous result into operand A, latches the
// result into the EX/WB register and writes it into the 8x8 register file
// one edge later. Also provides the bypassed register-file read port used
// by the ID stage.
//
// Optional feature macro: ALU_ADD_EN
//   defined   : ALUSrc=0 gives A+Imm, EX_WB_Carry captures the carry-out
//   undefined : ALUSrc=0 gives A (register move), EX_WB_Carry tied to 0
//
// Ports:
//   Clk, Reset                 rising-edge clock, async active-high reset
//   ID_EX_RegWrite             instruction in EX writes a register
//   ID_EX_ALUSrc               1 = immediate result, 0 = register-source result
//   ID_EX_Read_Data            source operand value captured in ID
//   ID_EX_Imm_Data             immediate field
//   ID_EX_Read_Reg_Num         source register of the instruction in EX
//   ID_EX_Write_Reg_Num        destination register of the instruction in EX
//   ID_Read_Reg_Num            ID-stage read address
//   ID_Read_Data               ID-stage read data (combinational, bypassed)
//   EX_WB_RegWrite             registered write enable
//   EX_WB_Write_Reg_Num        registered destination
//   EX_WB_Write_Data           registered result
//   EX_WB_Carry                registered carry flag
module ex_wb_stage (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ID_EX_RegWrite,
  input  logic       ID_EX_ALUSrc,
  input  logic [7:0] ID_EX_Read_Data,
  input  logic [7:0] ID_EX_Imm_Data,
  input  logic [2:0] ID_EX_Read_Reg_Num,
  input  logic [2:0] ID_EX_Write_Reg_Num,
  input  logic [2:0] ID_Read_Reg_Num,
  output logic [7:0] ID_Read_Data,
  output logic       EX_WB_RegWrite,
  output logic [2:0] EX_WB_Write_Reg_Num,
  output logic [7:0] EX_WB_Write_Data,
  output logic       EX_WB_Carry
);

`ifdef ALU_ADD_EN
  // Unsigned 8-bit add with the carry kept as the 9th bit; the low byte wraps.
  function automatic logic [8:0] add_wrap(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
`endif

  logic [7:0] rf [8];

  logic       fwd_a_p0;
  logic [7:0] op_a_p0;
  logic [7:0] result_p0;

  // ---- EX stage (p0): operand forwarding and result select ----
  // Forwarding is qualified by RegWrite so a bubble's latched data is never used.
  assign fwd_a_p0 = EX_WB_RegWrite && (EX_WB_Write_Reg_Num == ID_EX_Read_Reg_Num);
  assign op_a_p0  = fwd_a_p0 ? EX_WB_Write_Data : ID_EX_Read_Data;

`ifdef ALU_ADD_EN
  logic [8:0] sum_p0;
  logic       carry_p0;

  assign sum_p0    = add_wrap(op_a_p0, ID_EX_Imm_Data);
  assign result_p0 = ID_EX_ALUSrc ? ID_EX_Imm_Data : sum_p0[7:0];
  assign carry_p0  = ID_EX_ALUSrc ? 1'b0 : sum_p0[8];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      EX_WB_Carry <= 1'b0;
    end else begin
      EX_WB_Carry <= carry_p0;
    end
  end
`else
  assign result_p0   = ID_EX_ALUSrc ? ID_EX_Imm_Data : op_a_p0;
  assign EX_WB_Carry = 1'b0;
`endif

  // ---- EX/WB register (p1): loaded every cycle, no stall ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      EX_WB_RegWrite      <= 1'b0;
      EX_WB_Write_Reg_Num <= 3'd0;
      EX_WB_Write_Data    <= 8'd0;
    end else begin
      EX_WB_RegWrite      <= ID_EX_RegWrite;
      EX_WB_Write_Reg_Num <= ID_EX_Write_Reg_Num;
      EX_WB_Write_Data    <= result_p0;
    end
  end

  // ---- WB stage: register file write (all registers writable, incl. R0) ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= 8'd0;
      end
    end else if (EX_WB_RegWrite) begin
      rf[EX_WB_Write_Reg_Num] <= EX_WB_Write_Data;
    end
  end

  // ID read port: a write pending in EX/WB is younger than the RF contents.
  assign ID_Read_Data = (EX_WB_RegWrite && (EX_WB_Write_Reg_Num == ID_Read_Reg_Num))
                        ? EX_WB_Write_Data : rf[ID_Read_Reg_Num];

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Execute and write-back stage of the 8-bit pipelined core. It sits directly downstream of the ID/EX pipeline register and consumes its control, operand and destination fields. Each cycle it selects the ALU result, with forwarding from the previous result, and latches it into an internal EX/WB register. It owns the 8x8 register file and provides the bypassed read port that the ID stage uses to produce `Read_Data`.

## Interface
Parameters: none (datapath 8 bits, 8 registers, fixed).
- `Clk`  input  1  rising-edge clock
- `Reset`  input  1  asynchronous, active-high; clears all state
- `ID_EX_RegWrite`  input  1  instruction in EX writes a register
- `ID_EX_ALUSrc`  input  1  1 = immediate result, 0 = register-source result
- `ID_EX_Read_Data`  input  8  source operand value captured in ID
- `ID_EX_Imm_Data`  input  8  immediate field
- `ID_EX_Read_Reg_Num`  input  3  source register number of the instruction in EX
- `ID_EX_Write_Reg_Num`  input  3  destination register number
- `ID_Read_Reg_Num`  input  3  ID-stage register-file read address
- `ID_Read_Data`  output  8  ID-stage read data, combinational, bypassed
- `EX_WB_RegWrite`  output  1  registered write enable
- `EX_WB_Write_Reg_Num`  output  3  registered destination
- `EX_WB_Write_Data`  output  8  registered result
- `EX_WB_Carry`  output  1  registered carry flag (0 when `ALU_ADD_EN` is undefined)

## Operation
- Operand A forwarding: A = `EX_WB_Write_Data` when `EX_WB_RegWrite`=1 and `EX_WB_Write_Reg_Num`==`ID_EX_Read_Reg_Num`. Otherwise A = `ID_EX_Read_Data`.
- Result: `ALUSrc`=1 gives `Imm_Data`. `ALUSrc`=0 gives A, or A+Imm when `ALU_ADD_EN` is defined.
- EX/WB register: on each rising edge it loads RegWrite, Write_Reg_Num and the result. Carry loads bit 8 of the add when `ALUSrc`=0, otherwise 0. It is loaded every cycle; there is no stall or enable.
- Register file: RF[0..7], 8 bits each. On each rising edge with `EX_WB_RegWrite`=1, RF[`EX_WB_Write_Reg_Num`] is loaded with `EX_WB_Write_Data`. All registers are writable, including R0.
- ID read port: `ID_Read_Data` = `EX_WB_Write_Data` when `EX_WB_RegWrite`=1 and the numbers match. Otherwise it is RF[`ID_Read_Reg_Num`].
- `RegWrite`=0 instructions pass through and produce no RF write. Their data field is still latched, but it is never forwarded because forwarding is qualified by RegWrite.
- Arithmetic: 8-bit unsigned with wrap-around; the carry is the 9th bit.

## Timing
- EX latency is 1 cycle: inputs sampled at edge N appear on the EX_WB outputs after edge N.
- RF write occurs at edge N+1, so the register holds the new value from N+1 onward.
- Back-to-back dependency (the next instruction in EX reads the same register) is resolved by EX forwarding with zero stall.
- An instruction in ID reading a register whose write is pending in EX/WB is resolved by the ID bypass. Its operand is therefore correct when it is captured into ID/EX.
- Two consecutive writes to the same register: the forward and bypass always reflect the youngest (EX/WB) value.
- Reset (asynchronous, any time):
  - all RF entries = 0
  - `EX_WB_RegWrite`=0, `EX_WB_Write_Reg_Num`=0, `EX_WB_Write_Data`=0, `EX_WB_Carry`=0
  - any write in flight is discarded
  - after Reset falls, the first edge loads normally

## Configuration
- `ALU_ADD_EN` defined: when `ALUSrc`=0 the result is A+Imm and `EX_WB_Carry` captures the carry-out.
- `ALU_ADD_EN` undefined: when `ALUSrc`=0 the result is A (register move). `EX_WB_Carry` is held at 0 and there is no adder logic.

## Test plan
- Reset mid-run: with R3=0x55 and a write pending, assert Reset. Required: all EX_WB outputs 0, `ID_Read_Data` reads 0 for every address, and no write occurs after release.
- Immediate load: ALUSrc=1, Imm=0xA5, Write_Reg=2, RegWrite=1. Required: after 1 edge, EX_WB_Write_Data=0xA5 and Reg_Num=2; after 2 edges, ID reads of R2 return 0xA5.
- EX forward: cycle 1 loads R1=0x10 (imm). Cycle 2 is ALUSrc=0, Read_Reg=1, stale Read_Data=0x00, Imm=0x05, Write_Reg=4. Required: R4=0x15 with `ALU_ADD_EN` defined, 0x10 without.
- ID bypass: while EX_WB holds {RegWrite=1, R6, 0x3C}, set ID_Read_Reg_Num=6. Required: ID_Read_Data=0x3C in the same cycle, before the RF write.
- Carry/wrap (`ALU_ADD_EN`): A=0xF0, Imm=0x20, ALUSrc=0. Required: Write_Data=0x10 and Carry=1. Then ALUSrc=1 gives Carry=0.
- RegWrite=0 bubble: RegWrite=0, Write_Reg=5, Imm=0x77. Required: R5 is unchanged, and a following instruction reading R5 gets the RF value, not 0x77.
